sobel_window_gen: RTL and testbench

//  Producer side of the 3x3 window interface consumed by the Sobel gradient stage.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_line_buffer.sv | 28 ++
 rtl/sobel_window_gen.sv | 169 ++++++++++++++++
 tb/tb_sobel_window_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window producer: pixel layout and control FSM states.
package sobel_pkg;

  localparam int unsigned PIX_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: registered read, read-before-write on the same address.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output pixel_t        rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pixel_t        wr_data_i
);

  pixel_t mem_q [DEPTH];
  pixel_t rd_q;

  // Nonblocking read and write in one block give the old word on a same-address hit.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 interior windows: position counters, two line buffers,
// one alignment stage matching the RAM read, and the 3x3 shift array.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  localparam int unsigned CW    = $clog2(WIDTH),
  localparam int unsigned RW    = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [PIX_W-1:0] x00,
  output logic [PIX_W-1:0] x01,
  output logic [PIX_W-1:0] x02,
  output logic [PIX_W-1:0] x10,
  output logic [PIX_W-1:0] x11,
  output logic [PIX_W-1:0] x12,
  output logic [PIX_W-1:0] x20,
  output logic [PIX_W-1:0] x21,
  output logic [PIX_W-1:0] x22,
  output logic             win_valid,
  output logic [RW-1:0]    win_row,
  output logic [CW-1:0]    win_col,
  output logic             frame_done
);

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, pos_col;
  logic [RW-1:0]  row_q, row_d, pos_row;
  logic           accept;

  logic           v1_q;
  pixel_t         pix1_q;
  logic [RW-1:0]  row1_q;
  logic [CW-1:0]  col1_q;
  pixel_t         lb1_rd, lb2_rd;

  pixel_t         win_q [3][3];
  logic           win_valid_q, frame_done_q;
  logic [RW-1:0]  win_row_q;
  logic [CW-1:0]  win_col_q;
  logic           interior1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // An sof pixel is always (0,0), whether it starts a frame or restarts one.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = in_valid && (in_sof || (state_q == ACTIVE));
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    if (accept) begin
      state_d = ACTIVE;
      if (pos_col == CW'(WIDTH - 1)) begin
        col_d = '0;
        if (pos_row == RW'(HEIGHT - 1)) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = pos_row + RW'(1);
        end
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  // lb2 is fed from lb1's read port one cycle later, so it sees lb1's pre-write word.
  sobel_line_buffer #(.DEPTH(WIDTH), .AW(CW)) u_lb1 (
    .clk       (clk),
    .rd_en_i   (accept),
    .rd_addr_i (pos_col),
    .rd_data_o (lb1_rd),
    .wr_en_i   (accept),
    .wr_addr_i (pos_col),
    .wr_data_i (pixel_t'(in_pixel))
  );

  sobel_line_buffer #(.DEPTH(WIDTH), .AW(CW)) u_lb2 (
    .clk       (clk),
    .rd_en_i   (accept),
    .rd_addr_i (pos_col),
    .rd_data_o (lb2_rd),
    .wr_en_i   (v1_q),
    .wr_addr_i (col1_q),
    .wr_data_i (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      pix1_q <= '0;
      row1_q <= '0;
      col1_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        pix1_q <= pixel_t'(in_pixel);
        row1_q <= pos_row;
        col1_q <= pos_col;
      end
    end
  end

  assign interior1 = (row1_q >= RW'(2)) && (col1_q >= CW'(2));

  // Window shift and output strobes, aligned with the line-buffer read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= v1_q && interior1;
      frame_done_q <= v1_q && (row1_q == RW'(HEIGHT - 1)) && (col1_q == CW'(WIDTH - 1));
      if (v1_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= pix1_q;
        if (interior1) begin
          win_row_q <= row1_q - RW'(1);
          win_col_q <= col1_q - CW'(1);
        end
      end
    end
  end

  assign x00        = win_q[0][0];
  assign x01        = win_q[0][1];
  assign x02        = win_q[0][2];
  assign x10        = win_q[1][0];
  assign x11        = win_q[1][1];
  assign x12        = win_q[1][2];
  assign x20        = win_q[2][0];
  assign x21        = win_q[2][1];
  assign x22        = win_q[2][2];
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 frame: a frame-image model predicts
// every interior window, a negedge monitor matches DUT windows against the queue.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [23:0] in_pixel = '0;
  logic [23:0] x00, x01, x02, x10, x11, x12, x20, x21, x22;
  logic        win_valid, frame_done;
  logic [1:0]  win_row, win_col;

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .x00        (x00),
    .x01        (x01),
    .x02        (x02),
    .x10        (x10),
    .x11        (x11),
    .x12        (x12),
    .x20        (x20),
    .x21        (x21),
    .x22        (x22),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] w [9];
    int          row;
    int          col;
    bit          fd;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [23:0] img [H][W];
  bit          m_active = 1'b0;
  int          mr = 0;
  int          mc = 0;
  int          ecnt = 0;
  logic        rst_s = 1'b1;
  bit          done = 1'b0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) begin
    ecnt  <= ecnt + 1;
    rst_s <= reset;
  end

  // One input cycle; the model keeps the current frame image and predicts the window.
  task automatic step(input bit v, input bit s, input logic [23:0] p);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    if (v && (s || m_active)) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 9; i++) e.w[i] = img[mr - 2 + i / 3][mc - 2 + i % 3];
        e.row = mr - 1;
        e.col = mc - 1;
        e.fd  = (mr == H - 1) && (mc == W - 1);
        e.cyc = ecnt + 2;
        q.push_back(e);
      end
      m_active = 1'b1;
      if (mc == W - 1) begin
        mc = 0;
        if (mr == H - 1) begin
          mr = 0;
          m_active = 1'b0;
        end else begin
          mr++;
        end
      end else begin
        mc++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    m_active = 1'b0;
    mr = 0;
    mc = 0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Whole frame with sof on (0,0); gap applies the repeating valid pattern 1,0,0,1.
  task automatic frame(input int base, input bit gap, input bit rnd);
    int k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap) begin
          while ((k % 4 == 1) || (k % 4 == 2)) begin
            step(1'b0, 1'b0, 24'($urandom));
            k++;
          end
          k++;
        end
        step(1'b1, (r == 0) && (c == 0), rnd ? 24'($urandom) : 24'(base + r * W + c));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    frame(0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 24'($urandom));
    frame(0, 1'b0, 1'b0);
    idle(2);
    frame(0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, 24'(200 + i));
    frame(0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 11; i++) step(1'b1, i == 0, 24'(300 + i));
    do_reset(2);
    frame(0, 1'b0, 1'b0);
    idle(2);
    for (int f = 0; f < 3; f++) frame(0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom % 4) != 0;
      step(v, v && (($urandom % 16) == 0), 24'($urandom));
      if (i == 200) do_reset(1);
    end
    idle(5);
    done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    logic [23:0] act [9];
    exp_t        e;
    bit          ok;
    act = '{x00, x01, x02, x10, x11, x12, x20, x21, x22};
    if (done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (rst_s) begin
      q.delete();
      total++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_row !== 2'd0 || win_col !== 2'd0 ||
          (|{x00, x01, x02, x10, x11, x12, x20, x21, x22}) !== 1'b0) begin
        bad++;
        $display("FAIL reset_zero: got valid=%b fd=%b row=%0d col=%0d x11=%h, want all 0",
                 win_valid, frame_done, win_row, win_col, x11);
      end
    end else begin
      while (q.size() > 0 && q[0].cyc < ecnt) begin
        total++;
        bad++;
        $display("FAIL missing_window: centre (%0d,%0d) due at edge %0d, got no window",
                 q[0].row, q[0].col, q[0].cyc);
        void'(q.pop_front());
      end
      if (frame_done === 1'b1 && win_valid !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL frame_done_alone: got frame_done=1 with win_valid=%b, want win_valid=1", win_valid);
      end
      if (win_valid === 1'b1) begin
        total++;
        if (q.size() == 0 || q[0].cyc != ecnt) begin
          bad++;
          $display("FAIL unexpected_window: got centre (%0d,%0d) at edge %0d, want no window",
                   win_row, win_col, ecnt);
        end else begin
          e  = q.pop_front();
          ok = (int'(win_row) == e.row) && (int'(win_col) == e.col) && (frame_done == e.fd);
          for (int i = 0; i < 9; i++) if (act[i] !== e.w[i]) ok = 1'b0;
          if (!ok) begin
            bad++;
            $display("FAIL window_data: got (%0d,%0d) fd=%b x=%h %h %h %h %h %h %h %h %h want (%0d,%0d) fd=%b x=%h %h %h %h %h %h %h %h %h",
                     win_row, win_col, frame_done, act[0], act[1], act[2], act[3], act[4],
                     act[5], act[6], act[7], act[8], e.row, e.col, e.fd, e.w[0], e.w[1],
                     e.w[2], e.w[3], e.w[4], e.w[5], e.w[6], e.w[7], e.w[8]);
          end
        end
      end
    end
  end

endmodule
